// File: rtl/clkmult_if.sv
// Sample-path bundle for the clock multiplier: strobe, four mV inputs, four mV outputs.
// The master drives strobe and inputs; the slave (the core) drives the outputs.
interface clkmult_if #(
  parameter int W = 16
);
  logic                sample_strobe;
  logic signed [W-1:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;

  modport master (
    output sample_strobe, sample_in0, sample_in1, sample_in2, sample_in3,
    input  sample_out0, sample_out1, sample_out2, sample_out3
  );
  modport slave (
    input  sample_strobe, sample_in0, sample_in1, sample_in2, sample_in3,
    output sample_out0, sample_out1, sample_out2, sample_out3
  );
endinterface

// File: rtl/clkmult.sv
// Clock multiplier: measures the input-0 clock period in samples and regenerates
// phase-locked x1/x2/x4/x8 clocks, hard-resynced on every input rising edge.

// One divider lane: free-running phase counter over P>>K, high for the first P>>(K+1).
module clkmult_lane #(
  parameter int PERIOD_W = 16,
  parameter int K        = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe,
  input  logic                resync,
  input  logic                lock_nxt,
  input  logic [PERIOD_W-1:0] p_cur,
  input  logic [PERIOD_W-1:0] p_nxt,
  output logic                hi
);
  logic [PERIOD_W-1:0] c, c_nxt, pk, pk_nxt, hk_nxt;

  always_comb begin
    pk     = p_cur >> K;
    pk_nxt = p_nxt >> K;
    hk_nxt = p_nxt >> (K + 1);
    if (resync || c == pk - PERIOD_W'(1)) c_nxt = '0;
    else                                  c_nxt = c + PERIOD_W'(1);
  end

  // Output is computed from next-state values so it lands 1 clk after the strobe.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c  <= '0;
      hi <= 1'b0;
    end else if (strobe) begin
      c  <= c_nxt;
      hi <= lock_nxt && pk_nxt >= PERIOD_W'(2) && c_nxt < hk_nxt;
    end
endmodule

module clkmult #(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2,
  parameter int PERIOD_W  = 16
) (
  input logic       clk,
  input logic       rst,
  clkmult_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam logic signed [W-1:0] TH_RISE = W'(2000 <<< FP_OFFSET);
  localparam logic signed [W-1:0] TH_FALL = W'(500 <<< FP_OFFSET);
  localparam logic signed [W-1:0] OUT_HI  = W'(5000 <<< FP_OFFSET);
  localparam logic [PERIOD_W-1:0] SAT     = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t                state, state_nxt;
  logic                  last_hi, rise, sat, lock_edge, lock_nxt;
  logic [PERIOD_W-1:0]   cnt, p, p_nxt;
  logic [NUM_LANES-1:0]  lane_hi;
  logic                  unused_ins;

  assign unused_ins = ^{bus.sample_in1, bus.sample_in2, bus.sample_in3};

  assign rise      = bus.sample_in0 > TH_RISE && !last_hi;
  assign sat       = cnt == SAT;
  // A saturated count is not a period; such an edge only restarts measurement.
  assign lock_edge = rise && !sat && state != IDLE;
  assign p_nxt     = lock_edge ? cnt + PERIOD_W'(1) : p;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_hi <= 1'b0;
      cnt     <= '0;
      p       <= '0;
    end else if (bus.sample_strobe) begin
      if (bus.sample_in0 > TH_RISE)      last_hi <= 1'b1;
      else if (bus.sample_in0 < TH_FALL) last_hi <= 1'b0;
      if (rise)      cnt <= '0;
      else if (!sat) cnt <= cnt + PERIOD_W'(1);
      p <= p_nxt;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst)                    state <= IDLE;
    else if (bus.sample_strobe) state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = MEASURE;
      default: if (rise)     state_nxt = sat ? MEASURE : LOCKED;
               else if (sat) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lock_nxt = (state_nxt == LOCKED);
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    clkmult_lane #(.PERIOD_W(PERIOD_W), .K(k)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .strobe   (bus.sample_strobe),
      .resync   (rise),
      .lock_nxt (lock_nxt),
      .p_cur    (p),
      .p_nxt    (p_nxt),
      .hi       (lane_hi[k])
    );
  end

  assign bus.sample_out0 = lane_hi[0] ? OUT_HI : '0;
  assign bus.sample_out1 = lane_hi[1] ? OUT_HI : '0;
  assign bus.sample_out2 = lane_hi[2] ? OUT_HI : '0;
  assign bus.sample_out3 = lane_hi[3] ? OUT_HI : '0;
endmodule

// File: tb/tb_clkmult.sv
// Randomized + directed bench for clkmult against a phase/modulo reference model.
module tb_clkmult;
  localparam int TH_RISE = 2000 * 4;
  localparam int TH_FALL = 500 * 4;
  localparam int HI_VAL  = 5000 * 4;
  localparam int SATV    = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clkmult_if #(.W(16)) bus ();
  clkmult dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // Reference: mode 0 idle / 1 measuring / 2 locked; phase = strobes since last edge.
  int m_mode, m_lh, m_since, m_p, m_phase;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_lh = 0; m_since = 0; m_p = 0; m_phase = 0;
  endfunction

  function automatic void model_step(input int raw);
    bit r, s;
    r = raw > TH_RISE && m_lh == 0;
    s = m_since >= SATV;
    if (raw > TH_RISE)      m_lh = 1;
    else if (raw < TH_FALL) m_lh = 0;
    if (r) begin
      if (m_mode != 0 && !s) begin
        m_mode = 2;
        m_p    = m_since + 1;
      end else m_mode = 1;
      m_since = 0;
      m_phase = 0;
    end else begin
      if (s) m_mode = 0;
      else   m_since++;
      m_phase++;
    end
  endfunction

  function automatic int exp_out(input int k);
    int pk;
    pk = m_p / (1 << k);
    if (m_mode == 2 && pk >= 2 && (m_phase % pk) < pk / 2) return HI_VAL;
    return 0;
  endfunction

  function automatic int dut_out(input int k);
    case (k)
      0:       return int'(bus.sample_out0);
      1:       return int'(bus.sample_out1);
      2:       return int'(bus.sample_out2);
      default: return int'(bus.sample_out3);
    endcase
  endfunction

  task automatic check_outs();
    for (int k = 0; k < 4; k++) chk($sformatf("out%0d", k), dut_out(k), exp_out(k));
  endtask

  // One sample: in0 is scrambled between strobes to prove nothing advances without one.
  task automatic strobe_raw(input int raw, input int gap);
    bus.sample_in0 = 16'(raw);
    bus.sample_in1 = 16'($urandom);
    bus.sample_in2 = 16'($urandom);
    bus.sample_in3 = 16'($urandom);
    bus.sample_strobe = 1'b1;
    @(posedge clk);
    #1 bus.sample_strobe = 1'b0;
    bus.sample_in0 = 16'($urandom);
    model_step(raw);
    @(negedge clk);
    check_outs();
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check_outs();
    end
  endtask

  task automatic sq(input int period, input int n, input int hi, input int lo, input int gap);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < period; j++)
        strobe_raw((j < (period + 1) / 2) ? hi : lo, gap);
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_strobe = 1'b0;
    bus.sample_in0 = '0; bus.sample_in1 = '0; bus.sample_in2 = '0; bus.sample_in3 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs();
    rst = 1'b0;
    @(negedge clk);

    // period 16, x1..x8 at 8/8, 4/4, 2/2, 1/1
    sq(16, 4, HI_VAL, 0, 1);
    // lock edge, out0 high, then async reset mid-cycle
    strobe_raw(HI_VAL, 0);
    chk("pre_rst_out0", dut_out(0), HI_VAL);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(negedge clk);
    rst = 1'b0;
    strobe_raw(0, 0);
    strobe_raw(HI_VAL, 1);
    for (int i = 0; i < 5; i++) strobe_raw(0, 0);
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // ramp: only 2500mV crosses; the later lock period exposes any spurious edge
    strobe_raw(0, 0); strobe_raw(1500 * 4, 0); strobe_raw(400 * 4, 0);
    strobe_raw(1500 * 4, 0); strobe_raw(2500 * 4, 0); strobe_raw(2500 * 4, 0);
    for (int i = 0; i < 6; i++) strobe_raw(0, 0);
    sq(12, 3, HI_VAL, 0, 0);

    // exact thresholds: 8000 is not a rise, 2000 is not a fall
    strobe_raw(8000, 0); strobe_raw(8001, 0); strobe_raw(2000, 0);
    strobe_raw(8001, 0); strobe_raw(1999, 0); strobe_raw(0, 0);
    strobe_raw(8001, 0); strobe_raw(0, 0);

    // period 6: out2/out3 stay low
    sq(6, 4, HI_VAL, 0, 1);

    // period 16 then shortened to 10 mid-run
    sq(16, 3, HI_VAL, 0, 0);
    strobe_raw(HI_VAL, 0);
    for (int i = 0; i < 9; i++) strobe_raw(0, 0);
    sq(10, 3, HI_VAL, 0, 0);

    // random square waves and noisy levels
    for (int r = 0; r < 30; r++)
      sq($urandom_range(2, 40), $urandom_range(2, 4), $urandom_range(2001, 5000) * 4,
         $urandom_range(0, 499) * 4, $urandom_range(0, 2));
    for (int i = 0; i < 80; i++) strobe_raw($urandom_range(0, 24000) - 2000, $urandom_range(0, 1));

    // lock at 16, hold low through counter saturation, relock at 20
    sq(16, 3, HI_VAL, 0, 0);
    strobe_raw(HI_VAL, 0);
    for (int i = 0; i < SATV + 4; i++) strobe_raw(0, 0);
    sq(20, 3, HI_VAL, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
